// File: rtl/fifo_rd_stream.sv
// Read-side consumer for async_fifo_top: drains the FIFO read port into a 3-entry
// elastic buffer and presents it as a valid/ready stream framed into PKT_LEN-beat packets.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  pkt_done,
  output logic [CNT_WIDTH-1:0]  pkt_cnt
);

  localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

  logic                  r_run;
  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [1:0]            r_wr_ptr;
  logic [1:0]            r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_buf [3];
  logic [15:0]           r_beat_cnt;
  logic                  r_pkt_done;
  logic [CNT_WIDTH-1:0]  r_pkt_cnt;

  logic [2:0]            w_fill;
  logic                  w_pop;
  logic                  w_last;

  // Credit check counts the in-flight word so the buffer can never be oversubscribed.
  assign w_fill     = {1'b0, r_occ} + {2'b00, r_inflight};
  assign fifo_rd_en = r_run && !fifo_empty && (w_fill < 3'd3);

  assign m_valid  = (r_occ != 2'd0);
  assign m_data   = r_buf[r_rd_ptr];
  assign w_last   = (r_beat_cnt == LAST_BEAT);
  assign m_last   = w_last;
  assign w_pop    = m_valid && m_ready;
  assign pkt_done = r_pkt_done;
  assign pkt_cnt  = r_pkt_cnt;

  // r_run holds off issuing until the first edge after reset release.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_run      <= 1'b0;
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= fifo_rd_en;
      r_occ      <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
      if (r_inflight)
        r_wr_ptr <= (r_wr_ptr == 2'd2) ? 2'd0 : r_wr_ptr + 2'd1;
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == 2'd2) ? 2'd0 : r_rd_ptr + 2'd1;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      for (int i = 0; i < 3; i++)
        r_buf[i] <= '0;
    end else if (r_inflight) begin
      r_buf[r_wr_ptr] <= fifo_rd_data;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_beat_cnt <= 16'd0;
      r_pkt_done <= 1'b0;
      r_pkt_cnt  <= '0;
    end else begin
      r_pkt_done <= w_pop && w_last;
      if (w_pop)
        r_beat_cnt <= w_last ? 16'd0 : r_beat_cnt + 16'd1;
      if (w_pop && w_last)
        r_pkt_cnt <= r_pkt_cnt + 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge rd_clk) disable iff (!rd_rst_n) w_fill <= 3'd3);

endmodule
